// File: rtl/truth_table_sweeper.sv
// Walks a small combinational block through every input vector, captures its
// truth table and compares each sample against an expected table latched at start.
module truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] expected,
  output logic [3:0]  dut_in,
  input  logic        dut_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] captured_table,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic [3:0]  first_err,
  output logic        first_err_valid
);

  localparam int NV = 1 << N_IN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [3:0]    LAST_IDX = 4'(NV - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SETTLE - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_r, state_s;
  logic [3:0]    idx_r, idx_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [15:0]   exp_r, exp_s;
  logic [3:0]    dut_in_r, dut_in_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic [15:0]   table_r, table_s;
  logic          pass_r, pass_s;
  logic [4:0]    err_r, err_s;
  logic [3:0]    ferr_r, ferr_s;
  logic          ferr_v_r, ferr_v_s;

  // Next-state and next-output logic for the sweep sequencer.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    cnt_s    = cnt_r;
    exp_s    = exp_r;
    dut_in_s = dut_in_r;
    busy_s   = busy_r;
    done_s   = 1'b0;
    table_s  = table_r;
    pass_s   = pass_r;
    err_s    = err_r;
    ferr_s   = ferr_r;
    ferr_v_s = ferr_v_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          idx_s    = 4'd0;
          cnt_s    = '0;
          dut_in_s = 4'd0;
          exp_s    = expected;
          table_s  = 16'h0000;
          err_s    = 5'd0;
          ferr_s   = 4'd0;
          ferr_v_s = 1'b0;
          pass_s   = 1'b0;
          busy_s   = 1'b1;
          state_s  = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r != CNT_MAX) begin
          cnt_s = cnt_r + CW'(1);
        end else begin
          table_s[idx_r] = dut_out;
          if (dut_out != exp_r[idx_r]) begin
            // Saturate so a miscounted sweep can never wrap back to "pass".
            if (err_r != 5'd16) begin
              err_s = err_r + 5'd1;
            end else begin
              err_s = err_r;
            end
            if (!ferr_v_r) begin
              ferr_s   = idx_r;
              ferr_v_s = 1'b1;
            end else begin
              ferr_s = ferr_r;
            end
          end else begin
            err_s = err_r;
          end
          cnt_s = '0;
          if (idx_r == LAST_IDX) begin
            busy_s   = 1'b0;
            done_s   = 1'b1;
            pass_s   = (err_s == 5'd0);
            dut_in_s = 4'd0;
            state_s  = IDLE;
          end else begin
            idx_s    = idx_r + 4'd1;
            dut_in_s = idx_r + 4'd1;
          end
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      idx_r    <= 4'd0;
      cnt_r    <= '0;
      exp_r    <= 16'h0000;
      dut_in_r <= 4'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      table_r  <= 16'h0000;
      pass_r   <= 1'b0;
      err_r    <= 5'd0;
      ferr_r   <= 4'd0;
      ferr_v_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      idx_r    <= idx_s;
      cnt_r    <= cnt_s;
      exp_r    <= exp_s;
      dut_in_r <= dut_in_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      table_r  <= table_s;
      pass_r   <= pass_s;
      err_r    <= err_s;
      ferr_r   <= ferr_s;
      ferr_v_r <= ferr_v_s;
    end
  end

  assign dut_in          = dut_in_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign captured_table  = table_r;
  assign pass            = pass_r;
  assign err_count       = err_r;
  assign first_err       = ferr_r;
  assign first_err_valid = ferr_v_r;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: four instances with different N_IN/SETTLE,
// each driving a table-defined fake DUT, checked against a table-level model.
module tb_truth_table_sweeper;

  // Per instance (index 0..3): N_IN = 2,3,4,2 and SETTLE = 1,1,1,3
  localparam logic [15:0] NI_P = {4'd2, 4'd4, 4'd3, 4'd2};
  localparam logic [15:0] ST_P = {4'd3, 4'd1, 4'd1, 4'd1};

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  start_v;
  logic [15:0] exp_a [4];
  logic [15:0] fn_a [4];
  logic [3:0]  dut_out_v;
  logic [3:0]  dut_in_a [4];
  logic [3:0]  busy_v, done_v, pass_v, fev_v;
  logic [15:0] tab_a [4];
  logic [4:0]  err_a [4];
  logic [3:0]  fe_a [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gen_u
    assign dut_out_v[g] = fn_a[g][dut_in_a[g]];
    truth_table_sweeper #(
      .N_IN  (int'(NI_P[g*4 +: 4])),
      .SETTLE(int'(ST_P[g*4 +: 4]))
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start_v[g]),
      .expected       (exp_a[g]),
      .dut_in         (dut_in_a[g]),
      .dut_out        (dut_out_v[g]),
      .busy           (busy_v[g]),
      .done           (done_v[g]),
      .captured_table (tab_a[g]),
      .pass           (pass_v[g]),
      .err_count      (err_a[g]),
      .first_err      (fe_a[g]),
      .first_err_valid(fev_v[g])
    );
  end

  function automatic logic [15:0] tbl_xor();
    logic [15:0] t = 16'h0;
    for (int v = 0; v < 4; v++) t[v] = v[1] ^ v[0];
    return t;
  endfunction

  function automatic logic [15:0] tbl_g();
    logic [15:0] t = 16'h0;
    logic a, b, c;
    for (int v = 0; v < 8; v++) begin
      a = v[2]; b = v[1]; c = v[0];
      t[v] = (a & c) | (b & ~c) | (a & b);
    end
    return t;
  endfunction

  function automatic logic [15:0] tbl_h();
    logic [15:0] t = 16'h0;
    logic a, b, c, d, abc, ncd;
    for (int v = 0; v < 16; v++) begin
      a = v[3]; b = v[2]; c = v[1]; d = v[0];
      abc = a & b & c;
      ncd = ~(c | d);
      t[v] = d | ~(abc | ncd) | (ncd & abc);
    end
    return t;
  endfunction

  function automatic void chk_zero(input int u, input string nm);
    checks++;
    if (dut_in_a[u] !== 4'd0 || busy_v[u] !== 1'b0 || done_v[u] !== 1'b0 ||
        tab_a[u] !== 16'h0 || pass_v[u] !== 1'b0 || err_a[u] !== 5'd0 ||
        fe_a[u] !== 4'd0 || fev_v[u] !== 1'b0) begin
      failures++;
      $display("FAIL %s u%0d: got dut_in=%h busy=%b done=%b table=%h pass=%b err=%0d fe=%h fev=%b, want all 0",
               nm, u, dut_in_a[u], busy_v[u], done_v[u], tab_a[u], pass_v[u], err_a[u], fe_a[u], fev_v[u]);
    end
  endfunction

  // One full sweep on instance u. pre=1: start is already asserted by the caller.
  // restart_at>=0: pulse start and scramble expected in that cycle (must be ignored).
  // chain=1: assert start in the done cycle so the next call begins immediately.
  task automatic run_sweep(input int u, input logic [15:0] fn, input logic [15:0] ex,
                           input bit pre, input int restart_at, input bit chain, input string nm);
    int ni, st, nv, total, errs, first;
    logic [15:0] mask, diff;
    ni = int'(NI_P[u*4 +: 4]);
    st = int'(ST_P[u*4 +: 4]);
    nv = 1 << ni;
    total = nv * st;
    mask = (nv == 16) ? 16'hFFFF : 16'((32'd1 << nv) - 32'd1);
    diff = (fn ^ ex) & mask;
    errs = $countones(diff);
    first = 0;
    for (int i = 15; i >= 0; i--) if (diff[i]) first = i;
    fn_a[u]  = fn;
    exp_a[u] = ex;
    if (!pre) begin
      @(negedge clk);
      start_v[u] = 1'b1;
    end
    @(posedge clk); #1;
    start_v[u] = 1'b0;
    checks++;
    if (tab_a[u] !== 16'h0 || err_a[u] !== 5'd0 || pass_v[u] !== 1'b0 || fev_v[u] !== 1'b0) begin
      failures++;
      $display("FAIL %s clear: got table=%h err=%0d pass=%b fev=%b, want 0", nm, tab_a[u], err_a[u], pass_v[u], fev_v[u]);
    end
    for (int k = 0; k < total; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      start_v[u] = 1'b0;
      checks++;
      if (busy_v[u] !== 1'b1 || done_v[u] !== 1'b0 || dut_in_a[u] !== 4'(k / st)) begin
        failures++;
        $display("FAIL %s run k=%0d: got busy=%b done=%b dut_in=%0d, want 1 0 %0d",
                 nm, k, busy_v[u], done_v[u], dut_in_a[u], k / st);
      end
      if (k == restart_at) begin
        start_v[u] = 1'b1;
        exp_a[u]   = ~ex;
      end
    end
    @(posedge clk); #1;
    start_v[u] = 1'b0;
    checks++;
    if (done_v[u] !== 1'b1 || busy_v[u] !== 1'b0 || dut_in_a[u] !== 4'd0) begin
      failures++;
      $display("FAIL %s done: got done=%b busy=%b dut_in=%0d, want 1 0 0", nm, done_v[u], busy_v[u], dut_in_a[u]);
    end
    checks++;
    if (tab_a[u] !== (fn & mask) || err_a[u] !== 5'(errs) || pass_v[u] !== (errs == 0) ||
        fev_v[u] !== (errs != 0) || (errs != 0 && fe_a[u] !== 4'(first))) begin
      failures++;
      $display("FAIL %s result: got table=%h err=%0d pass=%b fev=%b fe=%0d, want %h %0d %b %b %0d",
               nm, tab_a[u], err_a[u], pass_v[u], fev_v[u], fe_a[u],
               fn & mask, errs, errs == 0, errs != 0, first);
    end
    if (chain) begin
      start_v[u] = 1'b1;
    end else begin
      @(posedge clk); #1;
      checks++;
      if (done_v[u] !== 1'b0 || busy_v[u] !== 1'b0 || pass_v[u] !== (errs == 0)) begin
        failures++;
        $display("FAIL %s after: got done=%b busy=%b pass=%b, want 0 0 %b", nm, done_v[u], busy_v[u], pass_v[u], errs == 0);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 4; u++) chk_zero(u, "reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_xor();
    run_sweep(0, tbl_xor(), 16'h0006, 1'b0, -1, 1'b0, "xor");
  endtask

  task automatic test_g();
    run_sweep(1, tbl_g(), 16'h00E4, 1'b0, -1, 1'b0, "g");
  endtask

  task automatic test_h();
    run_sweep(2, tbl_h(), 16'hAEEE, 1'b0, -1, 1'b0, "h");
    run_sweep(2, tbl_h(), 16'hAEEF, 1'b0, -1, 1'b0, "h_err");
  endtask

  task automatic test_settle3();
    run_sweep(3, tbl_xor(), 16'h0006, 1'b0, 4, 1'b0, "settle3");
  endtask

  task automatic test_back_to_back();
    run_sweep(0, tbl_xor(), 16'h0006, 1'b0, -1, 1'b1, "b2b_first");
    run_sweep(0, tbl_xor(), 16'h0009, 1'b1, -1, 1'b0, "b2b_second");
  endtask

  task automatic test_reset_mid();
    fn_a[2]  = tbl_h();
    exp_a[2] = 16'hAEEE;
    @(negedge clk);
    start_v[2] = 1'b1;
    @(posedge clk); #1;
    start_v[2] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_zero(2, "reset_mid");
    rst = 1'b0;
    run_sweep(2, tbl_h(), 16'hAEEE, 1'b0, -1, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic [15:0] fn, ex;
    for (int it = 0; it < 8; it++) begin
      fn = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       ex = fn;
        1:       ex = fn ^ (16'h1 << $urandom_range(0, 15));
        2:       ex = fn ^ 16'($urandom);
        default: ex = ~fn;
      endcase
      run_sweep(it % 4, fn, ex, 1'b0, -1, 1'b0, "random");
    end
    run_sweep(2, tbl_h(), ~tbl_h(), 1'b0, -1, 1'b0, "all_wrong");
  endtask

  initial begin
    rst     = 1'b1;
    start_v = 4'd0;
    for (int u = 0; u < 4; u++) begin
      exp_a[u] = 16'h0;
      fn_a[u]  = 16'h0;
    end
    test_reset();
    test_xor();
    test_g();
    test_h();
    test_settle3();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Self-checking sequencer for the team's small combinational logic blocks (2–4 inputs, 1 output). On start, it drives every input vector from 0 to 2^N_IN−1 in turn. It holds each vector for SETTLE cycles, then samples the DUT output into a captured truth-table word. Each sample is compared against an expected truth table latched at start. At the end it reports pass/fail, the error count and the first failing vector, replacing hand-written per-vector testbench stimulus.

Parameters:
N_IN, 4, number of DUT inputs; legal 1..4.
SETTLE, 1, cycles each vector is held before sampling; legal ≥1.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  begin a sweep; sampled only in IDLE
expected  input  16  expected table, bit i = expected output for vector i; latched on accepted start; bits ≥2^N_IN ignored
dut_in  output  4  current vector, registered; {a,b,c,d} order, MSB = first DUT input; bits ≥N_IN are 0
dut_out  input  1  DUT output (f/g/h)
busy  output  1  high while a sweep is running
done  output  1  one-cycle pulse after the last sample
table  output  16  captured outputs, bit i = dut_out sampled for vector i
pass  output  1  1 if err_count==0 at completion; held until next start
err_count  output  5  number of mismatching vectors (0..16)
first_err  output  4  index of the first mismatching vector
first_err_valid  output  1  first_err holds a real index

Behaviour:
- Reset (rst=1 at edge, any state, including mid-sweep): state=IDLE. dut_in, busy, done, table, pass, err_count, first_err, first_err_valid all 0. Settle counter and index are 0.
- States: IDLE, RUN.
- IDLE, start=1 at edge E0:
  - idx←0, dut_in←0, cnt←0.
  - Latch expected; clear table, err_count, first_err, first_err_valid, pass.
  - busy←1; state←RUN.
- RUN, each edge:
  - If cnt<SETTLE−1: cnt++.
  - Else (sample edge):
    - table[idx]←dut_out.
    - If dut_out≠exp_latched[idx]: err_count++. If !first_err_valid: first_err←idx, first_err_valid←1.
    - If idx==2^N_IN−1: busy←0, done←1, pass←(final err_count==0, including this sample), state←IDLE, dut_in←0.
    - Else: idx++, dut_in←idx+1, cnt←0.
- Timing: the sample for vector i occurs at edge E0+(i+1)·SETTLE. done is high for exactly one cycle, starting at E0+2^N_IN·SETTLE. A sweep takes 2^N_IN·SETTLE cycles.
- done is deasserted on every other edge.
- start while busy: ignored, with no effect on idx, cnt or latched data.
- start in the done cycle (state is IDLE): accepted as a new sweep; pass/table clear at that edge.
- Changes on expected mid-sweep have no effect.
- table bits ≥2^N_IN stay 0.
- err_count never wraps; maximum is 16.

Test Plan:
1. N_IN=2, SETTLE=1, DUT=XOR, expected=0x0006, start pulsed at edge E0:
   - dut_in 0,1,2,3 on consecutive cycles.
   - done pulses 4 cycles after E0.
   - table=0x0006, pass=1, err_count=0, first_err_valid=0.
2. N_IN=3, DUT g=ac|bc'|ab, expected=0x00E4 -> table=0x00E4, pass=1.
3. N_IN=4, DUT h=d|nor(abc,~(c|d))|(~(c|d)&abc), expected=0xAEEE -> table=0xAEEE, pass=1.
4. Same DUT as scenario 3, expected=0xAEEF -> err_count=1, first_err=0, first_err_valid=1, pass=0, table=0xAEEE.
5. SETTLE=3, N_IN=2:
   - Each dut_in value held for 3 cycles.
   - done exactly 12 cycles after start.
   - start re-pulsed mid-sweep is ignored (done still at cycle 12).
6. rst asserted at cycle 5 of an N_IN=4 sweep -> next cycle all outputs 0, busy=0. A fresh start then completes normally with the correct table.
